fpu_divsqrt_iter: RTL and testbench

- Iterative, multi-cycle IEEE-754 divide and square-root unit, parametrised for single (32) or double (64) precision.
- Takes over fdiv/fsqrt from the combinational FPU datapath, so those ops no longer set the critical path.
- Sits beside the FPU in the execute stage. Operands and results move through valid/ready handshakes, with a flush for pipeline squash.

---
 rtl/fpu_divsqrt_iter.sv | 253 +++++++++++++++++++++++++
 tb/tb_fpu_divsqrt_iter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_divsqrt_iter.sv
// Iterative IEEE-754 divide / square-root unit (radix-2 restoring, flush-to-zero).
// One result bit per cycle; valid/ready on both sides, flush squashes the in-flight op.
module fpu_divsqrt_iter #(
    parameter int BUS_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op,
    input  logic [BUS_WIDTH-1:0] in1,
    input  logic [BUS_WIDTH-1:0] in2,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out,
    output logic [2:0]           flags
);
    localparam int EXP_W = (BUS_WIDTH == 32) ? 8 : 11;
    localparam int MAN_W = (BUS_WIDTH == 32) ? 23 : 52;
    localparam int NITER = MAN_W + 3;
    localparam int CW    = $clog2(NITER);
    localparam int XW    = EXP_W + 2;
    localparam int RW    = MAN_W + 6;
    localparam int QW    = MAN_W + 3;
    localparam int XRW   = 2 * MAN_W + 6;
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
    localparam logic [BUS_WIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ITER, S_ROUND, S_DONE} state_t;

    state_t                 state_q;
    logic                   in_ready_q, out_valid_q;
    logic [BUS_WIDTH-1:0]   out_q, a_q, b_q, spec_res_q;
    logic [2:0]             flags_q, spec_flg_q;
    logic                   op_q, spec_q, sign_q;
    logic signed [XW-1:0]   exp_q;
    logic [MAN_W:0]         div_q;
    logic [RW-1:0]          rem_q;
    logic [XRW-1:0]         rad_q;
    logic [QW-1:0]          quo_q;
    logic [CW-1:0]          cnt_q;

    // ---------------- unpack / classify ----------------
    logic                 s1, s2;
    logic [EXP_W-1:0]     e1, e2;
    logic [MAN_W-1:0]     f1, f2;
    logic                 z1, z2, inf1, inf2, nan1, nan2, snan1, snan2;
    logic [MAN_W:0]       m1, m2;
    logic                 pre;
    logic signed [XW-1:0] e1x, e2x, ue, div_exp_d, sq_exp_d;
    logic [RW-1:0]        div_rem_d;
    logic [XRW-1:0]       sq_rad_d;
    logic                 sp_hit_d;
    logic [BUS_WIDTH-1:0] sp_val_d;
    logic [2:0]           sp_flg_d;

    assign {s1, e1, f1} = a_q;
    assign {s2, e2, f2} = b_q;

    always_comb begin
        z1    = (e1 == '0);
        z2    = (e2 == '0);
        inf1  = (e1 == '1) && (f1 == '0);
        inf2  = (e2 == '1) && (f2 == '0);
        nan1  = (e1 == '1) && (f1 != '0);
        nan2  = (e2 == '1) && (f2 != '0);
        snan1 = nan1 && !f1[MAN_W-1];
        snan2 = nan2 && !f2[MAN_W-1];
        m1    = {1'b1, f1};
        m2    = {1'b1, f2};
        e1x   = signed'({2'b00, e1});
        e2x   = signed'({2'b00, e2});
        // Pre-shift keeps the quotient in [1,2) so the first result bit is the hidden bit.
        pre       = (m1 < m2);
        div_exp_d = e1x - e2x + BIAS - signed'({{(XW-1){1'b0}}, pre});
        div_rem_d = pre ? RW'({m1, 1'b0}) : RW'(m1);
        ue        = e1x - BIAS;
        sq_exp_d  = (ue >>> 1) + BIAS;
        sq_rad_d  = {(ue[0] ? {m1, 1'b0} : {1'b0, m1}), {(MAN_W+4){1'b0}}};

        sp_hit_d = 1'b1;
        sp_val_d = '0;
        sp_flg_d = '0;
        if (!op_q) begin
            if (nan1 || nan2) begin
                sp_val_d = QNAN;
                sp_flg_d = {snan1 | snan2, 2'b00};
            end else if ((z1 && z2) || (inf1 && inf2)) begin
                sp_val_d = QNAN;
                sp_flg_d = 3'b100;
            end else if (inf1) begin
                sp_val_d = {s1 ^ s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (z2) begin
                sp_val_d = {s1 ^ s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                sp_flg_d = 3'b010;
            end else if (inf2 || z1) begin
                sp_val_d = {s1 ^ s2, {(BUS_WIDTH-1){1'b0}}};
            end else begin
                sp_hit_d = 1'b0;
            end
        end else begin
            if (nan1) begin
                sp_val_d = QNAN;
                sp_flg_d = {snan1, 2'b00};
            end else if (z1) begin
                sp_val_d = {s1, {(BUS_WIDTH-1){1'b0}}};
            end else if (s1) begin
                sp_val_d = QNAN;
                sp_flg_d = 3'b100;
            end else if (inf1) begin
                sp_val_d = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                sp_hit_d = 1'b0;
            end
        end
    end

    // ---------------- one iteration step ----------------
    logic [RW-1:0] rem_sq, trial, d_ext, rem_d;
    logic [QW-1:0] quo_d;
    logic          ge;

    always_comb begin
        d_ext  = RW'(div_q);
        rem_sq = {rem_q[RW-3:0], rad_q[XRW-1 -: 2]};
        trial  = RW'({quo_q, 2'b01});
        if (op_q) begin
            ge    = (rem_sq >= trial);
            rem_d = ge ? rem_sq - trial : rem_sq;
        end else begin
            ge    = (rem_q >= d_ext);
            rem_d = (ge ? rem_q - d_ext : rem_q) << 1;
        end
        quo_d = {quo_q[QW-2:0], ge};
    end

    // ---------------- round to nearest even ----------------
    logic                 g_b, r_b, st_b, rup, carry, inexact, unused_hid;
    logic [MAN_W+1:0]     mr;
    logic [MAN_W-1:0]     frac;
    logic signed [XW-1:0] ex;
    logic [BUS_WIDTH-1:0] rnd_val_d;
    logic [2:0]           rnd_flg_d;

    always_comb begin
        g_b        = quo_q[1];
        r_b        = quo_q[0];
        st_b       = (rem_q != '0);
        rup        = g_b && (quo_q[2] || r_b || st_b);
        inexact    = g_b || r_b || st_b;
        mr         = {1'b0, quo_q[QW-1:2]} + {{(MAN_W+1){1'b0}}, rup};
        carry      = mr[MAN_W+1];
        unused_hid = mr[MAN_W];
        frac       = carry ? '0 : mr[MAN_W-1:0];
        ex         = exp_q + signed'({{(XW-1){1'b0}}, carry});
        if (spec_q) begin
            rnd_val_d = spec_res_q;
            rnd_flg_d = spec_flg_q;
        end else if (ex >= EMAX) begin
            rnd_val_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flg_d = 3'b001;
        end else if (ex <= 0) begin
            rnd_val_d = {sign_q, {(BUS_WIDTH-1){1'b0}}};
            rnd_flg_d = 3'b001;
        end else begin
            rnd_val_d = {sign_q, ex[EXP_W-1:0], frac};
            rnd_flg_d = {2'b00, inexact};
        end
    end

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 1'b0;
            spec_q      <= 1'b0;
            spec_res_q  <= '0;
            spec_flg_q  <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            rad_q       <= '0;
            quo_q       <= '0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    a_q        <= in1;
                    b_q        <= in2;
                    op_q       <= op;
                    in_ready_q <= 1'b0;
                    state_q    <= S_UNPACK;
                end
                // Specials pass through ROUND unchanged, giving a fixed two-cycle latency.
                S_UNPACK: begin
                    spec_q     <= sp_hit_d;
                    spec_res_q <= sp_val_d;
                    spec_flg_q <= sp_flg_d;
                    sign_q     <= op_q ? s1 : (s1 ^ s2);
                    exp_q      <= op_q ? sq_exp_d : div_exp_d;
                    div_q      <= m2;
                    rem_q      <= op_q ? '0 : div_rem_d;
                    rad_q      <= sq_rad_d;
                    quo_q      <= '0;
                    cnt_q      <= '0;
                    state_q    <= sp_hit_d ? S_ROUND : S_ITER;
                end
                S_ITER: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    rad_q <= rad_q << 2;
                    if (cnt_q == CW'(NITER - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_ROUND;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ROUND: begin
                    out_q       <= rnd_val_d;
                    flags_q     <= rnd_flg_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fpu_divsqrt_iter.sv
// Directed bench for fpu_divsqrt_iter: one double- and one single-precision instance
// sharing clock, reset and flush; expected values are hand-computed IEEE results.
module tb_fpu_divsqrt_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic        iv64 = 1'b0, op64 = 1'b0, or64 = 1'b0;
    logic [63:0] a64 = '0, b64 = '0;
    logic        ir64, ov64;
    logic [63:0] out64;
    logic [2:0]  fl64;

    logic        iv32 = 1'b0, op32 = 1'b0, or32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        ir32, ov32;
    logic [31:0] out32;
    logic [2:0]  fl32;

    always #5 clk = ~clk;

    fpu_divsqrt_iter #(.BUS_WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .op(op64),
        .in1(a64), .in2(b64), .flush(flush), .out_valid(ov64), .out_ready(or64),
        .out(out64), .flags(fl64)
    );

    fpu_divsqrt_iter #(.BUS_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op(op32),
        .in1(a32), .in2(b32), .flush(flush), .out_valid(ov32), .out_ready(or32),
        .out(out32), .flags(fl32)
    );

    // Launch one op, count edges from the accept edge to out_valid, then consume.
    task automatic go64(input logic o, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] r, output logic [2:0] f, output int lat);
        op64 = o; a64 = a; b64 = b; iv64 = 1'b1;
        @(negedge clk);
        iv64 = 1'b0;
        lat = 0;
        while (!ov64 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = out64;
        f = fl64;
        or64 = 1'b1;
        @(negedge clk);
        or64 = 1'b0;
    endtask

    task automatic go32(input logic o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [2:0] f, output int lat);
        op32 = o; a32 = a; b32 = b; iv32 = 1'b1;
        @(negedge clk);
        iv32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = out32;
        f = fl32;
        or32 = 1'b1;
        @(negedge clk);
        or32 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total += 8;
        if (ir64 !== 1'b1)  begin bad++; $display("FAIL reset_in_ready64 got %b want 1", ir64); end
        if (ov64 !== 1'b0)  begin bad++; $display("FAIL reset_out_valid64 got %b want 0", ov64); end
        if (out64 !== '0)   begin bad++; $display("FAIL reset_out64 got %h want 0", out64); end
        if (fl64 !== 3'b0)  begin bad++; $display("FAIL reset_flags64 got %b want 000", fl64); end
        if (ir32 !== 1'b1)  begin bad++; $display("FAIL reset_in_ready32 got %b want 1", ir32); end
        if (ov32 !== 1'b0)  begin bad++; $display("FAIL reset_out_valid32 got %b want 0", ov32); end
        if (out32 !== '0)   begin bad++; $display("FAIL reset_out32 got %h want 0", out32); end
        if (fl32 !== 3'b0)  begin bad++; $display("FAIL reset_flags32 got %b want 000", fl32); end
    endtask

    task automatic test_div64;
        logic [63:0] r; logic [2:0] f; int lat;
        go64(1'b0, 64'h4048800000000000, 64'h401C000000000000, r, f, lat);
        total += 3;
        if (r !== 64'h401C000000000000) begin bad++; $display("FAIL div64_out got %h want 401c000000000000", r); end
        if (f !== 3'b000) begin bad++; $display("FAIL div64_flags got %b want 000", f); end
        if (lat != 57)    begin bad++; $display("FAIL div64_latency got %0d want 57", lat); end
    endtask

    task automatic test_sqrt64;
        logic [63:0] r; logic [2:0] f; int lat;
        go64(1'b1, 64'h4048800000000000, 64'h0, r, f, lat);
        total += 3;
        if (r !== 64'h401C000000000000) begin bad++; $display("FAIL sqrt64_out got %h want 401c000000000000", r); end
        if (f !== 3'b000) begin bad++; $display("FAIL sqrt64_flags got %b want 000", f); end
        if (lat != 57)    begin bad++; $display("FAIL sqrt64_latency got %0d want 57", lat); end
    endtask

    task automatic test_single;
        logic [31:0] r; logic [2:0] f; int lat;
        go32(1'b0, 32'h3F800000, 32'h40400000, r, f, lat);
        total += 3;
        if (r !== 32'h3EAAAAAB) begin bad++; $display("FAIL div32_third_out got %h want 3eaaaaab", r); end
        if (f !== 3'b001) begin bad++; $display("FAIL div32_third_flags got %b want 001", f); end
        if (lat != 28)    begin bad++; $display("FAIL div32_latency got %0d want 28", lat); end
        go32(1'b1, 32'h40000000, 32'h0, r, f, lat);
        total += 2;
        if (r !== 32'h3FB504F3) begin bad++; $display("FAIL sqrt32_two_out got %h want 3fb504f3", r); end
        if (f !== 3'b001) begin bad++; $display("FAIL sqrt32_two_flags got %b want 001", f); end
        go32(1'b0, 32'hC0C00000, 32'h40000000, r, f, lat);
        total += 2;
        if (r !== 32'hC0400000) begin bad++; $display("FAIL div32_neg_out got %h want c0400000", r); end
        if (f !== 3'b000) begin bad++; $display("FAIL div32_neg_flags got %b want 000", f); end
    endtask

    typedef struct {
        logic        o;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic [2:0]  f;
        int          lat;
    } vec_t;

    task automatic test_specials;
        vec_t v[10];
        logic [63:0] r; logic [2:0] f; int lat;
        v[0] = '{1'b0, 64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 3'b010, 2};
        v[1] = '{1'b1, 64'hBFF0000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 3'b100, 2};
        v[2] = '{1'b0, 64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 3'b100, 2};
        v[3] = '{1'b0, 64'hC000000000000000, 64'h7FF0000000000000, 64'h8000000000000000, 3'b000, 2};
        v[4] = '{1'b0, 64'h7FF0000000000000, 64'hC000000000000000, 64'hFFF0000000000000, 3'b000, 2};
        v[5] = '{1'b1, 64'h8000000000000000, 64'h0000000000000000, 64'h8000000000000000, 3'b000, 2};
        v[6] = '{1'b0, 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 3'b100, 2};
        v[7] = '{1'b1, 64'h7FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 3'b000, 2};
        v[8] = '{1'b0, 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FF0000000000000, 3'b001, 57};
        v[9] = '{1'b0, 64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 3'b001, 57};
        for (int i = 0; i < 10; i++) begin
            go64(v[i].o, v[i].a, v[i].b, r, f, lat);
            total += 3;
            if (r !== v[i].r) begin bad++; $display("FAIL special%0d_out got %h want %h", i, r, v[i].r); end
            if (f !== v[i].f) begin bad++; $display("FAIL special%0d_flags got %b want %b", i, f, v[i].f); end
            if (lat != v[i].lat) begin bad++; $display("FAIL special%0d_latency got %0d want %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_backpressure;
        int n;
        op64 = 1'b0; a64 = 64'h4048800000000000; b64 = 64'h401C000000000000; iv64 = 1'b1;
        @(negedge clk);
        iv64 = 1'b0;
        n = 0;
        while (!ov64 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 57) begin bad++; $display("FAIL bp_latency got %0d want 57", n); end
        // Offer a new op while the result is stalled; it must not be taken.
        a64 = 64'h3FF0000000000000; b64 = 64'h4008000000000000; iv64 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total += 4;
            if (out64 !== 64'h401C000000000000) begin bad++; $display("FAIL bp_out_stable got %h want 401c000000000000", out64); end
            if (fl64 !== 3'b000) begin bad++; $display("FAIL bp_flags_stable got %b want 000", fl64); end
            if (ir64 !== 1'b0)   begin bad++; $display("FAIL bp_in_ready got %b want 0", ir64); end
            if (ov64 !== 1'b1)   begin bad++; $display("FAIL bp_out_valid got %b want 1", ov64); end
        end
        iv64 = 1'b0;
        or64 = 1'b1;
        @(negedge clk);
        or64 = 1'b0;
        total += 2;
        if (ov64 !== 1'b0) begin bad++; $display("FAIL bp_release_valid got %b want 0", ov64); end
        if (ir64 !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b want 1", ir64); end
        @(negedge clk);
        total++;
        if (ir64 !== 1'b1) begin bad++; $display("FAIL bp_not_accepted got %b want 1", ir64); end
    endtask

    task automatic test_flush_reset;
        int seen;
        op64 = 1'b0; a64 = 64'h4048800000000000; b64 = 64'h401C000000000000; iv64 = 1'b1;
        @(negedge clk);
        iv64 = 1'b0;
        repeat (11) @(negedge clk);
        flush = 1'b1; iv64 = 1'b1;
        @(negedge clk);
        flush = 1'b0; iv64 = 1'b0;
        total += 2;
        if (ir64 !== 1'b1) begin bad++; $display("FAIL flush_in_ready got %b want 1", ir64); end
        if (ov64 !== 1'b0) begin bad++; $display("FAIL flush_out_valid got %b want 0", ov64); end
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (ov64 !== 1'b0) seen++;
        end
        total += 2;
        if (seen != 0)     begin bad++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
        if (ir64 !== 1'b1) begin bad++; $display("FAIL flush_idle got %b want 1", ir64); end
        iv64 = 1'b1;
        @(negedge clk);
        iv64 = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (ir64 !== 1'b0) begin bad++; $display("FAIL midop_busy got %b want 0", ir64); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total += 4;
        if (ir64 !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got %b want 1", ir64); end
        if (ov64 !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got %b want 0", ov64); end
        if (out64 !== '0)  begin bad++; $display("FAIL midrst_out got %h want 0", out64); end
        if (fl64 !== 3'b0) begin bad++; $display("FAIL midrst_flags got %b want 000", fl64); end
    endtask

    initial begin
        test_reset();
        test_div64();
        test_sqrt64();
        test_single();
        test_specials();
        test_backpressure();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
